// File: rtl/wb_queue.sv
// Register-file writeback queue: merges ALU and load-path writes in order,
// drains one per cycle to the register file, and forwards pending data to readers.
module wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_wa,
  input  logic [7:0]               mem_wd,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_wa,
  input  logic [7:0]               alu_wd,
  output logic                     we,
  output logic [4:0]               wa1,
  output logic [7:0]               wd1,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     fwd1_hit,
  output logic [7:0]               fwd1_data,
  output logic                     fwd2_hit,
  output logic [7:0]               fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    wa_q [DEPTH];
  logic [7:0]    wd_q [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] alu_idx;
  logic [PW-1:0] idx;
  logic [CW-1:0] space;
  logic          mem_push;
  logic          alu_push;
  logic          pop;

  // Space comes from registered count only; a same-edge pop frees nothing yet.
  assign space     = CW'(DEPTH) - count;
  assign mem_ready = (space != '0);
  assign alu_ready = (space >= CW'(2)) | ((space == CW'(1)) & ~mem_valid);

  // r0 writes complete the handshake but are dropped here.
  assign mem_push = ~reset & mem_valid & mem_ready & (mem_wa != '0);
  assign alu_push = ~reset & alu_valid & alu_ready & (alu_wa != '0);
  assign pop      = (count != '0);
  assign alu_idx  = wptr + PW'(mem_push);

  always_ff @(posedge clk) begin
    if (mem_push) begin
      wa_q[wptr] <= mem_wa;
      wd_q[wptr] <= mem_wd;
    end
    if (alu_push) begin
      wa_q[alu_idx] <= alu_wa;
      wd_q[alu_idx] <= alu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PW'(pop);
      wptr  <= wptr + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  assign we  = pop;
  assign wa1 = pop ? wa_q[rptr] : '0;
  assign wd1 = pop ? wd_q[rptr] : '0;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count) begin
        if ((ra1 != '0) && (wa_q[idx] == ra1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = wd_q[idx];
        end
        if ((ra2 != '0) && (wa_q[idx] == ra2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = wd_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a queue-based reference model.
module tb_wb_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_valid = 1'b0, alu_valid = 1'b0;
  logic       mem_ready, alu_ready;
  logic [4:0] mem_wa = '0, alu_wa = '0, ra1 = '0, ra2 = '0;
  logic [7:0] mem_wd = '0, alu_wd = '0;
  logic       we, fwd1_hit, fwd2_hit;
  logic [4:0] wa1;
  logic [7:0] wd1, fwd1_data, fwd2_data;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] q_wa[$];
  logic [7:0] q_wd[$];

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .we(we), .wa1(wa1), .wd1(wd1), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] observed();
    return {we, wa1, wd1, count, mem_ready, alu_ready,
            fwd1_hit, fwd1_data, fwd2_hit, fwd2_data};
  endfunction

  // Expected outputs from the pending-write list and current inputs.
  function automatic logic [36:0] expected();
    int         sz = q_wa.size();
    int         space = 4 - sz;
    logic       mr = (space >= 1);
    logic       ar = (space >= 2) || (space == 1 && !mem_valid);
    logic       h1 = 1'b0, h2 = 1'b0;
    logic [7:0] d1 = '0, d2 = '0;
    logic [4:0] hwa = '0;
    logic [7:0] hwd = '0;
    if (sz > 0) begin
      hwa = q_wa[0];
      hwd = q_wd[0];
    end
    foreach (q_wa[i]) begin
      if (ra1 != 0 && q_wa[i] == ra1) begin h1 = 1'b1; d1 = q_wd[i]; end
      if (ra2 != 0 && q_wa[i] == ra2) begin h2 = 1'b1; d2 = q_wd[i]; end
    end
    return {(sz != 0), hwa, hwd, 3'(sz), mr, ar, h1, d1, h2, d2};
  endfunction

  // Clock the model through one rising edge, then settle 1 time unit later.
  task automatic advance(output logic macc, output logic aacc);
    int         space = 4 - q_wa.size();
    logic [4:0] mwa = mem_wa, awa = alu_wa;
    logic [7:0] mwd = mem_wd, awd = alu_wd;
    macc = !reset && mem_valid && (space >= 1);
    aacc = !reset && alu_valid && ((space >= 2) || (space == 1 && !mem_valid));
    @(posedge clk);
    if (reset) begin
      q_wa.delete();
      q_wd.delete();
    end else begin
      if (q_wa.size() > 0) begin
        void'(q_wa.pop_front());
        void'(q_wd.pop_front());
      end
      if (macc && mwa != 0) begin q_wa.push_back(mwa); q_wd.push_back(mwd); end
      if (aacc && awa != 0) begin q_wa.push_back(awa); q_wd.push_back(awd); end
    end
    #1;
  endtask

  task automatic tick();
    logic m, a;
    advance(m, a);
  endtask

  task automatic test_reset_and_single();
    reset = 1'b1;
    tick(); tick();
    #4;
    n_checks++;
    if ({we, wa1, wd1, count, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, mem_ready, alu_ready}
        !== {1'b0, 5'd0, 8'd0, 3'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got we=%0b wa1=%0d wd1=%0h count=%0d mr=%0b ar=%0b required 0/0/0/0/1/1",
               we, wa1, wd1, count, mem_ready, alu_ready);
    end
    tick();
    reset = 1'b0;
    alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 8'h3C;
    #4;
    n_checks++;
    if (observed() !== expected()) begin
      n_fail++;
      $display("FAIL single_pre got %h required %h", observed(), expected());
    end
    tick();
    alu_valid = 1'b0;
    #4;
    n_checks++;
    if ({we, wa1, wd1, count} !== {1'b1, 5'd5, 8'h3C, 3'd1}) begin
      n_fail++;
      $display("FAIL single_write got we=%0b wa1=%0d wd1=%0h count=%0d required 1/5/3c/1", we, wa1, wd1, count);
    end
    tick();
    #4;
    n_checks++;
    if ({we, count} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL single_drained got we=%0b count=%0d required 0/0", we, count);
    end
  endtask

  task automatic test_r0();
    logic m, a;
    mem_valid = 1'b1; mem_wa = 5'd0; mem_wd = 8'hFF;
    #4;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_ready got %0b required 1", mem_ready);
    end
    advance(m, a);
    mem_valid = 1'b0;
    #4;
    n_checks++;
    if ({we, count} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL r0_dropped got we=%0b count=%0d required 0/0", we, count);
    end
  endtask

  task automatic test_simultaneous();
    mem_valid = 1'b1; mem_wa = 5'd3; mem_wd = 8'h11;
    alu_valid = 1'b1; alu_wa = 5'd4; alu_wd = 8'h22;
    #4;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #4;
    n_checks++;
    if ({we, wa1, wd1} !== {1'b1, 5'd3, 8'h11}) begin
      n_fail++;
      $display("FAIL simul_first got we=%0b wa1=%0d wd1=%0h required 1/3/11", we, wa1, wd1);
    end
    tick();
    #4;
    n_checks++;
    if ({we, wa1, wd1} !== {1'b1, 5'd4, 8'h22}) begin
      n_fail++;
      $display("FAIL simul_second got we=%0b wa1=%0d wd1=%0h required 1/4/22", we, wa1, wd1);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic m, a;
    int   next = 1;
    mem_valid = 1'b1; alu_valid = 1'b1;
    mem_wa = 5'(next); mem_wd = 8'(next * 3); next++;
    alu_wa = 5'(next); alu_wd = 8'(next * 3); next++;
    for (int c = 0; c < 12; c++) begin
      #4;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d got %h required %h", c, observed(), expected());
      end
      n_checks++;
      if (count > 3'd4) begin
        n_fail++;
        $display("FAIL bp_count_bound got %0d required <=4", count);
      end
      if (count == 3'd3) begin
        n_checks++;
        if (alu_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_alu_ready got %0b required 0", alu_ready);
        end
      end
      advance(m, a);
      if (m) begin mem_wa = 5'(next); mem_wd = 8'(next * 3); next++; end
      if (a) begin alu_wa = 5'(next); alu_wd = 8'(next * 3); next++; end
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #4;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL bp_drain cycle %0d got %h required %h", c, observed(), expected());
      end
      tick();
    end
  endtask

  task automatic test_forwarding();
    ra1 = 5'd7; ra2 = 5'd0;
    mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 8'h01;
    alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 8'h02;
    #4;
    n_checks++;
    if (fwd1_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_incoming got %0b required 0", fwd1_hit);
    end
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #4;
    n_checks++;
    if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count} !== {1'b1, 8'h02, 1'b0, 8'h00, 3'd2}) begin
      n_fail++;
      $display("FAIL fwd_both got hit1=%0b d1=%0h hit2=%0b d2=%0h count=%0d required 1/02/0/00/2",
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count);
    end
    tick();
    #4;
    n_checks++;
    if ({fwd1_hit, fwd1_data, fwd2_hit, count} !== {1'b1, 8'h02, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL fwd_one got hit1=%0b d1=%0h hit2=%0b count=%0d required 1/02/0/1",
               fwd1_hit, fwd1_data, fwd2_hit, count);
    end
    tick();
    #4;
    n_checks++;
    if ({fwd1_hit, fwd1_data} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL fwd_empty got hit1=%0b d1=%0h required 0/00", fwd1_hit, fwd1_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_wa = 5'd9;  mem_wd = 8'hA1;
    alu_valid = 1'b1; alu_wa = 5'd10; alu_wd = 8'hA2;
    tick();
    mem_wa = 5'd11; mem_wd = 8'hA3; alu_wa = 5'd12; alu_wd = 8'hA4;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    ra1 = 5'd11; ra2 = 5'd12;
    #1;
    n_checks++;
    if ({count, fwd1_hit, fwd2_hit} !== {3'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_filled got count=%0d hit1=%0b hit2=%0b required 3/1/1", count, fwd1_hit, fwd2_hit);
    end
    #1 reset = 1'b1;
    q_wa.delete(); q_wd.delete();
    #1;
    n_checks++;
    if ({we, wa1, wd1, count, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data}
        !== {1'b0, 5'd0, 8'd0, 3'd0, 1'b0, 8'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset got we=%0b count=%0d hit1=%0b hit2=%0b required 0/0/0/0",
               we, count, fwd1_hit, fwd2_hit);
    end
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      n_checks++;
      if ({we, count} !== {1'b0, 3'd0}) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d got we=%0b count=%0d required 0/0", c, we, count);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mem_valid = ($urandom_range(0, 99) < 60);
      alu_valid = ($urandom_range(0, 99) < 60);
      mem_wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      alu_wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      mem_wd = 8'($urandom);
      alu_wd = 8'($urandom);
      ra1 = 5'($urandom_range(0, 6));
      ra2 = 5'($urandom_range(0, 6));
      #4;
      n_checks++;
      if (observed() !== expected()) begin
        n_fail++;
        $display("FAIL random cycle %0d got %h required %h", c, observed(), expected());
      end
      tick();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  initial begin
    #1;
    test_reset_and_single();
    test_r0();
    test_simultaneous();
    test_backpressure();
    test_forwarding();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
